execute_stage_buf: RTL and testbench

Parametrised execute-stage pipeline register with a valid/ready handshake, placed between the ALU/execute logic and the memory/write-back stage of the processor pipeline. It captures data, instruction, register operand, the absolute-register operand and a configurable status-flag vector in a 2-entry skid buffer, so back-pressure from downstream never drops an instruction. It also supports a synchronous pipeline flush and keeps a sticky accumulation of retired flags. The opcode range that selects the absolute-register path and raises `reset_regs` is a parameter.

---
 rtl/execute_stage_buf_if.sv | 39 +++
 rtl/execute_stage_buf.sv | 149 ++++++++++++++
 tb/tb_execute_stage_buf.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_buf_if.sv
// Handshake and payload bundle between the execute stage and the
// memory/write-back stage. The slave side is the pipeline buffer itself.
interface execute_stage_buf_if #(
  parameter int DWIDTH = 32,
  parameter int NFLAGS = 7
) ();

  // Upstream (producer) side
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] data;
  logic [DWIDTH-1:0] instr;
  logic [DWIDTH-1:0] register;
  logic [DWIDTH-1:0] mux_register;
  logic [NFLAGS-1:0] flags_in;

  // Downstream (consumer) side
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] stored_data;
  logic [DWIDTH-1:0] stored_instr;
  logic [DWIDTH-1:0] stored_register;
  logic [DWIDTH-1:0] r_abs;
  logic [NFLAGS-1:0] RFlags;
  logic              reset_regs;

  modport slave (
    input  in_valid, data, instr, register, mux_register, flags_in, out_ready,
    output in_ready, out_valid, stored_data, stored_instr, stored_register,
           r_abs, RFlags, reset_regs
  );

  modport master (
    output in_valid, data, instr, register, mux_register, flags_in, out_ready,
    input  in_ready, out_valid, stored_data, stored_instr, stored_register,
           r_abs, RFlags, reset_regs
  );

endinterface

// File: rtl/execute_stage_buf.sv
// Execute-stage pipeline register: 2-entry skid buffer (head + skid) with a
// registered in_ready, synchronous flush and sticky accumulation of the flags
// of every retired (popped) entry.
module execute_stage_buf #(
  parameter int DWIDTH = 32,
  parameter int NFLAGS = 7,
  parameter int OPW    = 5,
  parameter int ABS_LO = 13,
  parameter int ABS_HI = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              sticky_clr,
  output logic [NFLAGS-1:0] sticky_flags,
  execute_stage_buf_if.slave bus
);

  localparam logic [OPW-1:0] ABS_LO_C = OPW'(ABS_LO);
  localparam logic [OPW-1:0] ABS_HI_C = OPW'(ABS_HI);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // One buffered instruction, already decoded for the absolute-register path
  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [DWIDTH-1:0] instr;
    logic [DWIDTH-1:0] register;
    logic [DWIDTH-1:0] abs_val;
    logic [NFLAGS-1:0] flags;
    logic              abs;
  } entry_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_in_ready;
  entry_t            r_head;
  entry_t            r_skid;
  entry_t            w_in_entry;
  logic [NFLAGS-1:0] r_sticky;
  logic [OPW-1:0]    w_opcode;
  logic              w_accept;
  logic              w_pop;
  logic              w_load_head_in;
  logic              w_load_head_skid;
  logic              w_load_skid;

  assign w_opcode = bus.instr[DWIDTH-1 -: OPW];
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_pop    = (r_state != EMPTY) & bus.out_ready;

  // Decode the offered entry; the absolute operand is forced to zero off-range
  always_comb begin
    w_in_entry          = '0;
    w_in_entry.data     = bus.data;
    w_in_entry.instr    = bus.instr;
    w_in_entry.register = bus.register;
    w_in_entry.flags    = bus.flags_in;
    w_in_entry.abs      = (w_opcode >= ABS_LO_C) && (w_opcode <= ABS_HI_C);
    w_in_entry.abs_val  = w_in_entry.abs ? bus.mux_register : '0;
  end

  // Occupancy next-state and which storage slot loads this cycle
  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_next   = ONE;
          w_load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_load_head_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = TWO;
          w_load_skid  = 1'b1;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen
        if (w_pop) begin
          w_state_next     = ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
    if (flush) begin
      w_state_next = EMPTY;
    end
  end

  // State, registered in_ready and entry storage; flush wipes the payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != TWO);
      if (w_load_head_in) begin
        r_head <= w_in_entry;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  // Sticky flags: clear first, then OR in the retiring head; flush keeps them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (sticky_clr ? '0 : r_sticky) | (w_pop ? r_head.flags : '0);
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.out_valid       = (r_state != EMPTY);
  assign bus.stored_data     = r_head.data;
  assign bus.stored_instr    = r_head.instr;
  assign bus.stored_register = r_head.register;
  assign bus.r_abs           = r_head.abs_val;
  assign bus.RFlags          = r_head.flags;
  assign bus.reset_regs      = r_head.abs;
  assign sticky_flags        = r_sticky;

endmodule

// File: tb/tb_execute_stage_buf.sv
// Bench for execute_stage_buf: directed scenarios followed by random traffic,
// checked against a FIFO reference model by a monitor on the falling edge.
module tb_execute_stage_buf;

  localparam int DW     = 32;
  localparam int NF     = 7;
  localparam int OPW    = 5;
  localparam int ABS_LO = 13;
  localparam int ABS_HI = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          sticky_clr;
  logic [NF-1:0] sticky_flags;

  execute_stage_buf_if #(.DWIDTH(DW), .NFLAGS(NF)) bus ();

  execute_stage_buf #(
    .DWIDTH(DW), .NFLAGS(NF), .OPW(OPW), .ABS_LO(ABS_LO), .ABS_HI(ABS_HI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .sticky_clr(sticky_clr),
    .sticky_flags(sticky_flags),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] instr;
    logic [DW-1:0] register;
    logic [DW-1:0] r_abs;
    logic [NF-1:0] flags;
    logic          rr;
  } exp_t;

  exp_t          q[$];
  exp_t          shown;
  logic [NF-1:0] sticky_m;
  int            errors = 0;
  int            checks = 0;
  bit            done   = 0;

  function automatic exp_t zero_exp();
    exp_t e;
    e.data = '0; e.instr = '0; e.register = '0; e.r_abs = '0;
    e.flags = '0; e.rr = 1'b0;
    return e;
  endfunction

  // Expected head contents for an accepted input, from the opcode range rule
  function automatic exp_t expect_of(input logic [DW-1:0] d, input logic [DW-1:0] i,
                                     input logic [DW-1:0] r, input logic [DW-1:0] m,
                                     input logic [NF-1:0] f);
    exp_t        e;
    int unsigned op;
    op         = int'(i >> (DW - OPW));
    e.data     = d;
    e.instr    = i;
    e.register = r;
    e.flags    = f;
    e.rr       = (op >= ABS_LO) && (op <= ABS_HI);
    e.r_abs    = e.rr ? m : '0;
    return e;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard: compare, then advance the reference model
  initial begin
    exp_t cur;
    logic pop;
    logic acc;
    q.delete();
    shown    = zero_exp();
    sticky_m = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      cur = (q.size() != 0) ? q[0] : shown;
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      chk("sticky_flags", 64'(sticky_flags), 64'(sticky_m));
      chk("stored_data", 64'(bus.stored_data), 64'(cur.data));
      chk("stored_instr", 64'(bus.stored_instr), 64'(cur.instr));
      chk("stored_register", 64'(bus.stored_register), 64'(cur.register));
      chk("r_abs", 64'(bus.r_abs), 64'(cur.r_abs));
      chk("RFlags", 64'(bus.RFlags), 64'(cur.flags));
      chk("reset_regs", 64'(bus.reset_regs), 64'(cur.rr));

      pop = (q.size() != 0) && bus.out_ready;
      acc = bus.in_valid && (q.size() < 2);
      if (rst) begin
        q.delete();
        shown    = zero_exp();
        sticky_m = '0;
      end else begin
        sticky_m = (sticky_clr ? '0 : sticky_m) | (pop ? q[0].flags : '0);
        if (pop) begin
          $display("pop  data=%h instr=%h flags=%h reset_regs=%b", q[0].data,
                   q[0].instr, q[0].flags, q[0].rr);
          if (q.size() == 1) shown = q[0];
          void'(q.pop_front());
        end
        if (flush) begin
          q.delete();
          shown = zero_exp();
        end else if (acc) begin
          q.push_back(expect_of(bus.data, bus.instr, bus.register,
                                bus.mux_register, bus.flags_in));
        end
      end
    end
  end

  // One clock of stimulus; inputs change shortly after the rising edge
  task automatic cyc(input bit v, input logic [OPW-1:0] op, input logic [NF-1:0] fl,
                     input bit ordy, input bit fls, input bit clr, input bit r);
    bus.in_valid     = v;
    bus.data         = $urandom;
    bus.instr        = {op, (DW-OPW)'($urandom)};
    bus.register     = $urandom;
    bus.mux_register = $urandom;
    bus.flags_in     = fl;
    bus.out_ready    = ordy;
    flush            = fls;
    sticky_clr       = clr;
    rst              = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [OPW-1:0] op;
    rst = 1'b1; flush = 1'b0; sticky_clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.data = '0; bus.instr = '0;
    bus.register = '0; bus.mux_register = '0; bus.flags_in = '0;
    @(posedge clk);
    @(posedge clk);
    #2;

    // Streaming with downstream always ready, opcodes around the range edges
    cyc(1, 5'd0,  7'h00, 1, 0, 0, 0);
    cyc(1, 5'd13, 7'h02, 1, 0, 0, 0);
    cyc(1, 5'd17, 7'h04, 1, 0, 0, 0);
    cyc(1, 5'd18, 7'h08, 1, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);

    // Back-pressure: fill both entries, offer a third while full, then drain
    cyc(1, 5'd1,  7'h10, 0, 0, 0, 0);
    cyc(1, 5'd14, 7'h20, 0, 0, 0, 0);
    cyc(1, 5'd2,  7'h40, 0, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);

    // Flush while full with a new entry offered
    cyc(1, 5'd15, 7'h01, 0, 0, 0, 0);
    cyc(1, 5'd16, 7'h02, 0, 0, 0, 0);
    cyc(1, 5'd13, 7'h03, 0, 1, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);

    // Sticky accumulation, with the last pop landing in the clear cycle
    cyc(0, 5'd0,  7'h00, 0, 0, 1, 0);
    cyc(1, 5'd3,  7'h01, 0, 0, 0, 0);
    cyc(1, 5'd4,  7'h20, 0, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);
    cyc(1, 5'd5,  7'h04, 1, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 1, 0);
    cyc(0, 5'd0,  7'h00, 0, 0, 0, 0);

    // Reset while holding one entry with downstream ready
    cyc(1, 5'd13, 7'h7f, 0, 0, 0, 0);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 1);
    cyc(0, 5'd0,  7'h00, 1, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OPW'($urandom_range(11, 19)) : OPW'($urandom);
      cyc(($urandom % 4) != 0, op, NF'($urandom), ($urandom % 3) != 0,
          ($urandom % 50) == 0, ($urandom % 16) == 0, ($urandom % 300) == 0);
    end

    for (int i = 0; i < 4; i++) cyc(0, 5'd0, 7'h00, 1, 0, 0, 0);
    done = 1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
